// File: rtl/tl_fifo_fixer_pkg.sv
// Shared widths, TileLink opcodes and beat-count helpers for the FIFO-ordering fixer.
package tl_fifo_fixer_pkg;

   localparam int unsigned SOURCE_W   = 3;
   localparam int unsigned ADDR_W     = 31;
   localparam int unsigned DATA_W     = 64;
   localparam int unsigned SIZE_W     = 4;
   localparam int unsigned DOMAIN_W   = 1;
   localparam int unsigned DOMAIN_LSB = 28;
   localparam int unsigned MAX_OUTS   = 4;

   localparam int unsigned NSRC    = 2 ** SOURCE_W;
   localparam int unsigned BB      = DATA_W / 8;
   localparam int unsigned LOG2_BB = $clog2(BB);
   localparam int unsigned OUTS_W  = $clog2(MAX_OUTS + 1);
   // Largest burst is 2**(2**SIZE_W-1) bytes; the counter holds remaining beats minus one.
   localparam int unsigned BEAT_W  = (2 ** SIZE_W - 1) - LOG2_BB;
   localparam int unsigned BEATS_W = BEAT_W + 1;

   localparam logic [2:0] A_PUT_FULL         = 3'd0;
   localparam logic [2:0] A_PUT_PARTIAL      = 3'd1;
   localparam logic [2:0] A_ARITHMETIC       = 3'd2;
   localparam logic [2:0] A_LOGICAL          = 3'd3;
   localparam logic [2:0] A_GET              = 3'd4;
   localparam logic [2:0] A_HINT             = 3'd5;
   localparam logic [2:0] D_ACCESS_ACK       = 3'd0;
   localparam logic [2:0] D_ACCESS_ACK_DATA  = 3'd1;
   localparam logic [2:0] D_HINT_ACK         = 3'd2;

   function automatic logic has_data_a(input logic [2:0] opcode);
      return opcode < 3'd4;
   endfunction

   function automatic logic has_data_d(input logic [2:0] opcode);
      return opcode[0];
   endfunction

   function automatic logic [BEATS_W-1:0] num_beats(input logic [SIZE_W-1:0] size,
                                                    input logic              has_data);
      logic [BEATS_W-1:0] beats;
      beats = BEATS_W'(1);
      if (has_data && (size > SIZE_W'(LOG2_BB))) begin
         beats = BEATS_W'(1) << (size - SIZE_W'(LOG2_BB));
      end
      return beats;
   endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Burst beat tracker: flags the first and last beat of each message on one channel.
module tl_beat_counter
   import tl_fifo_fixer_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              fire_i,
   input  logic [SIZE_W-1:0] size_i,
   input  logic              has_data_i,
   output logic              first_c_o,
   output logic              last_c_o
);

   logic [BEAT_W-1:0]  count_q, count_d;
   logic [BEATS_W-1:0] beats_c;

   assign beats_c   = num_beats(size_i, has_data_i);
   assign first_c_o = (count_q == '0);
   assign last_c_o  = first_c_o ? (beats_c == BEATS_W'(1)) : (count_q == BEAT_W'(1));

   // Load remaining-beats-minus-one on the first beat, count down otherwise.
   always_comb begin
      count_d = count_q;
      if (fire_i) begin
         if (first_c_o) begin
            count_d = BEAT_W'(beats_c - BEATS_W'(1));
         end else begin
            count_d = count_q - BEAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/tl_fifo_fixer_ordered.sv
// TileLink FIFO-ordering fixer: stalls a new A request whose source still has responses due from another domain.
// Define TL_FIFO_FIXER_STATS_EN to add the saturating stall_cycles counter port.
module tl_fifo_fixer_ordered
   import tl_fifo_fixer_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   output logic                auto_in_a_ready,
   input  logic                auto_in_a_valid,
   input  logic [2:0]          auto_in_a_bits_opcode,
   input  logic [2:0]          auto_in_a_bits_param,
   input  logic [SIZE_W-1:0]   auto_in_a_bits_size,
   input  logic [SOURCE_W-1:0] auto_in_a_bits_source,
   input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
   input  logic [BB-1:0]       auto_in_a_bits_mask,
   input  logic [DATA_W-1:0]   auto_in_a_bits_data,
   input  logic                auto_in_a_bits_corrupt,
   input  logic                auto_in_d_ready,
   output logic                auto_in_d_valid,
   output logic [2:0]          auto_in_d_bits_opcode,
   output logic [1:0]          auto_in_d_bits_param,
   output logic [SIZE_W-1:0]   auto_in_d_bits_size,
   output logic [SOURCE_W-1:0] auto_in_d_bits_source,
   output logic                auto_in_d_bits_sink,
   output logic                auto_in_d_bits_denied,
   output logic [DATA_W-1:0]   auto_in_d_bits_data,
   output logic                auto_in_d_bits_corrupt,
   input  logic                auto_out_a_ready,
   output logic                auto_out_a_valid,
   output logic [2:0]          auto_out_a_bits_opcode,
   output logic [2:0]          auto_out_a_bits_param,
   output logic [SIZE_W-1:0]   auto_out_a_bits_size,
   output logic [SOURCE_W-1:0] auto_out_a_bits_source,
   output logic [ADDR_W-1:0]   auto_out_a_bits_address,
   output logic [BB-1:0]       auto_out_a_bits_mask,
   output logic [DATA_W-1:0]   auto_out_a_bits_data,
   output logic                auto_out_a_bits_corrupt,
   output logic                auto_out_d_ready,
   input  logic                auto_out_d_valid,
   input  logic [2:0]          auto_out_d_bits_opcode,
   input  logic [1:0]          auto_out_d_bits_param,
   input  logic [SIZE_W-1:0]   auto_out_d_bits_size,
   input  logic [SOURCE_W-1:0] auto_out_d_bits_source,
   input  logic                auto_out_d_bits_sink,
   input  logic                auto_out_d_bits_denied,
   input  logic [DATA_W-1:0]   auto_out_d_bits_data,
   input  logic                auto_out_d_bits_corrupt
`ifdef TL_FIFO_FIXER_STATS_EN
   ,
   output logic [31:0]         stall_cycles
`endif
);

   logic                a_first_c, d_first_c;
   logic                a_last_unused, d_last_unused;
   logic                stall_c, a_fire_c, d_fire_c;
   logic [SOURCE_W-1:0] a_src_c, d_src_c;
   logic [DOMAIN_W-1:0] a_dom_c;
   logic [OUTS_W-1:0]   cnt_q [NSRC];
   logic [OUTS_W-1:0]   cnt_d [NSRC];
   logic [DOMAIN_W-1:0] dom_q [NSRC];
   logic [DOMAIN_W-1:0] dom_d [NSRC];

   assign a_src_c = auto_in_a_bits_source;
   assign d_src_c = auto_out_d_bits_source;
   assign a_dom_c = auto_in_a_bits_address[DOMAIN_LSB +: DOMAIN_W];

   // Only a message's first beat can stall; later beats belong to a request already admitted.
   assign stall_c = a_first_c && auto_in_a_valid && (cnt_q[a_src_c] != '0) &&
                    ((dom_q[a_src_c] != a_dom_c) || (cnt_q[a_src_c] == OUTS_W'(MAX_OUTS)));

   assign a_fire_c = auto_in_a_valid && auto_out_a_ready && !stall_c;
   assign d_fire_c = auto_out_d_valid && auto_in_d_ready;

   assign auto_in_a_ready         = auto_out_a_ready && !stall_c;
   assign auto_out_a_valid        = auto_in_a_valid && !stall_c;
   assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
   assign auto_out_a_bits_param   = auto_in_a_bits_param;
   assign auto_out_a_bits_size    = auto_in_a_bits_size;
   assign auto_out_a_bits_source  = auto_in_a_bits_source;
   assign auto_out_a_bits_address = auto_in_a_bits_address;
   assign auto_out_a_bits_mask    = auto_in_a_bits_mask;
   assign auto_out_a_bits_data    = auto_in_a_bits_data;
   assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;

   assign auto_out_d_ready        = auto_in_d_ready;
   assign auto_in_d_valid         = auto_out_d_valid;
   assign auto_in_d_bits_opcode   = auto_out_d_bits_opcode;
   assign auto_in_d_bits_param    = auto_out_d_bits_param;
   assign auto_in_d_bits_size     = auto_out_d_bits_size;
   assign auto_in_d_bits_source   = auto_out_d_bits_source;
   assign auto_in_d_bits_sink     = auto_out_d_bits_sink;
   assign auto_in_d_bits_denied   = auto_out_d_bits_denied;
   assign auto_in_d_bits_data     = auto_out_d_bits_data;
   assign auto_in_d_bits_corrupt  = auto_out_d_bits_corrupt;

   tl_beat_counter u_a_beats (
      .clk_i      (clock),
      .rst_i      (reset),
      .fire_i     (a_fire_c),
      .size_i     (auto_in_a_bits_size),
      .has_data_i (has_data_a(auto_in_a_bits_opcode)),
      .first_c_o  (a_first_c),
      .last_c_o   (a_last_unused)
   );

   tl_beat_counter u_d_beats (
      .clk_i      (clock),
      .rst_i      (reset),
      .fire_i     (d_fire_c),
      .size_i     (auto_out_d_bits_size),
      .has_data_i (has_data_d(auto_out_d_bits_opcode)),
      .first_c_o  (d_first_c),
      .last_c_o   (d_last_unused)
   );

   // Outstanding count per source; a response with nothing outstanding is ignored.
   always_comb begin
      for (int s = 0; s < int'(NSRC); s++) begin
         logic inc, dec;
         cnt_d[s] = cnt_q[s];
         dom_d[s] = dom_q[s];
         inc = a_fire_c && a_first_c && (a_src_c == SOURCE_W'(s));
         dec = d_fire_c && d_first_c && (d_src_c == SOURCE_W'(s)) && (cnt_q[s] != '0);
         if (inc && !dec) begin
            cnt_d[s] = cnt_q[s] + OUTS_W'(1);
         end else if (dec && !inc) begin
            cnt_d[s] = cnt_q[s] - OUTS_W'(1);
         end
         if (inc) begin
            dom_d[s] = a_dom_c;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < int'(NSRC); s++) begin
            cnt_q[s] <= '0;
            dom_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < int'(NSRC); s++) begin
            cnt_q[s] <= cnt_d[s];
            dom_q[s] <= dom_d[s];
         end
      end
   end

`ifdef TL_FIFO_FIXER_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall_c && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule
